// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: push side from fetch, pop side to decode.
interface fetch_queue_if #(
  parameter int AW = 8,
  parameter int IW = 9
);
  logic          push_valid;
  logic [AW-1:0] push_pc;
  logic [IW-1:0] push_instr;
  logic          push_ready;
  logic          fetch_stall;
  logic          pop_valid;
  logic [AW-1:0] pop_pc;
  logic [IW-1:0] pop_instr;
  logic          pop_ready;

  modport master (
    output push_valid, push_pc, push_instr, pop_ready,
    input  push_ready, fetch_stall, pop_valid, pop_pc, pop_instr
  );

  modport slave (
    input  push_valid, push_pc, push_instr, pop_ready,
    output push_ready, fetch_stall, pop_valid, pop_pc, pop_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} prefetch queue, first-word fall-through; push visible to pop one cycle later.
// Backpressure: push_ready = ~full (no full-bypass); flush empties the queue and drops that cycle's push.
module fetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 8,
  parameter  int IW    = 9,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                f_clk,
  input  logic                rst_n,
  input  logic                flush,
  fetch_queue_if.slave        q,
  output logic [CW-1:0]       count,
  output logic [15:0]         retire_cnt
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push_acc;
  logic          pop_acc;
  entry_t        head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Status depends only on registered count and push_valid, never on pop_ready.
  assign q.push_ready  = ~full;
  assign q.pop_valid   = ~empty;
  assign q.fetch_stall = q.push_valid & full;

  assign push_acc = q.push_valid & ~full & ~flush;
  assign pop_acc  = ~empty & q.pop_ready;

  assign head        = mem[rd_ptr];
  assign q.pop_pc    = head.pc;
  assign q.pop_instr = head.instr;

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge f_clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= '{pc: q.push_pc, instr: q.push_instr};
    end
  end

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A pop in the flush cycle was consumed by decode, so it still retires.
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (pop_acc && retire_cnt != 16'hFFFF) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

  logic        f_clk;
  logic        rst_n;
  logic        flush;
  logic [2:0]  count;
  logic [15:0] retire_cnt;
  int          n_chk;
  int          n_fail;

  fetch_queue_if #(.AW(8), .IW(9)) fq ();

  fetch_queue #(.DEPTH(4), .AW(8), .IW(9)) dut (
    .f_clk      (f_clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .q          (fq.slave),
    .count      (count),
    .retire_cnt (retire_cnt)
  );

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge f_clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [7:0] pc, input logic [8:0] ins, input logic pr);
    fq.push_valid = pv;
    fq.push_pc    = pc;
    fq.push_instr = ins;
    fq.pop_ready  = pr;
  endtask

  always @(negedge f_clk) begin
    if (rst_n) check_eq("count_bound", 32'(count <= 3'd4), 32'd1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    drive(1'b0, 8'h00, 9'h000, 1'b0);

    // Reset state
    repeat (2) @(posedge f_clk);
    @(negedge f_clk);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_pop_valid", 32'(fq.pop_valid), 32'd0);
    check_eq("rst_push_ready", 32'(fq.push_ready), 32'd1);
    check_eq("rst_fetch_stall", 32'(fq.fetch_stall), 32'd0);
    check_eq("rst_retire", 32'(retire_cnt), 32'd0);
    rst_n = 1'b1;

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), 9'(9'h100 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 9'h000, 1'b0);
    @(negedge f_clk);
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_push_ready", 32'(fq.push_ready), 32'd0);
    check_eq("fill_stall_idle", 32'(fq.fetch_stall), 32'd0);
    drive(1'b1, 8'h14, 9'h104, 1'b0);
    @(negedge f_clk);
    check_eq("full_stall", 32'(fq.fetch_stall), 32'd1);
    tick();
    drive(1'b0, 8'h00, 9'h000, 1'b0);
    @(negedge f_clk);
    check_eq("full_count_hold", 32'(count), 32'd4);

    // Drain in order; 0x14 must not appear
    tick();
    fq.pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge f_clk);
      check_eq("drain_valid", 32'(fq.pop_valid), 32'd1);
      check_eq("drain_pc", 32'(fq.pop_pc), 32'(8'h10 + i));
      check_eq("drain_instr", 32'(fq.pop_instr), 32'(9'h100 + i));
      tick();
    end
    fq.pop_ready = 1'b0;
    @(negedge f_clk);
    check_eq("drain_pop_valid", 32'(fq.pop_valid), 32'd0);
    check_eq("drain_count", 32'(count), 32'd0);
    check_eq("drain_retire", 32'(retire_cnt), 32'd4);

    // Simultaneous push/pop at count 2, crossing pointer wrap
    tick();
    drive(1'b1, 8'h50, 9'h050, 1'b0);
    tick();
    drive(1'b1, 8'h51, 9'h051, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h52 + i), 9'(9'h052 + i), 1'b1);
      @(negedge f_clk);
      check_eq("pp_count", 32'(count), 32'd2);
      check_eq("pp_pc", 32'(fq.pop_pc), 32'(8'h50 + i));
      tick();
    end
    drive(1'b0, 8'h00, 9'h000, 1'b0);
    @(negedge f_clk);
    check_eq("pp_count_end", 32'(count), 32'd2);
    check_eq("pp_retire", 32'(retire_cnt), 32'd12);

    // Flush with concurrent push and pop
    tick();
    drive(1'b1, 8'h5A, 9'h05A, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 8'h40, 9'h040, 1'b1);
    @(negedge f_clk);
    check_eq("flush_pre_count", 32'(count), 32'd3);
    check_eq("flush_pop_pc", 32'(fq.pop_pc), 32'h58);
    tick();
    flush = 1'b0;
    drive(1'b1, 8'h80, 9'h080, 1'b0);
    @(negedge f_clk);
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_pop_valid", 32'(fq.pop_valid), 32'd0);
    check_eq("flush_retire", 32'(retire_cnt), 32'd13);
    tick();
    drive(1'b0, 8'h00, 9'h000, 1'b1);
    @(negedge f_clk);
    check_eq("post_flush_valid", 32'(fq.pop_valid), 32'd1);
    check_eq("post_flush_pc", 32'(fq.pop_pc), 32'h80);
    check_eq("post_flush_count", 32'(count), 32'd1);
    tick();
    fq.pop_ready = 1'b0;
    @(negedge f_clk);
    check_eq("post_flush_empty", 32'(count), 32'd0);
    check_eq("post_flush_retire", 32'(retire_cnt), 32'd14);

    // Empty: no bypass
    tick();
    drive(1'b1, 8'h22, 9'h022, 1'b1);
    @(negedge f_clk);
    check_eq("nobypass_valid", 32'(fq.pop_valid), 32'd0);
    tick();
    drive(1'b0, 8'h00, 9'h000, 1'b1);
    @(negedge f_clk);
    check_eq("nobypass_next_valid", 32'(fq.pop_valid), 32'd1);
    check_eq("nobypass_next_pc", 32'(fq.pop_pc), 32'h22);
    tick();
    fq.pop_ready = 1'b0;
    @(negedge f_clk);
    check_eq("nobypass_retire", 32'(retire_cnt), 32'd15);
    check_eq("nobypass_count", 32'(count), 32'd0);

    // Saturation: 65540 pops
    tick();
    drive(1'b1, 8'h30, 9'h030, 1'b0);
    tick();
    for (int i = 0; i < 65539; i++) begin
      drive(1'b1, 8'(8'h31 + i), 9'(i), 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 9'h000, 1'b1);
    tick();
    fq.pop_ready = 1'b0;
    @(negedge f_clk);
    check_eq("sat_retire", 32'(retire_cnt), 32'hFFFF);
    check_eq("sat_count", 32'(count), 32'd0);

    // Async reset mid-cycle with entries in flight
    tick();
    drive(1'b1, 8'h61, 9'h061, 1'b0);
    tick();
    drive(1'b1, 8'h62, 9'h062, 1'b0);
    tick();
    drive(1'b0, 8'h00, 9'h000, 1'b0);
    check_eq("pre_arst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_retire", 32'(retire_cnt), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_pop_valid", 32'(fq.pop_valid), 32'd0);
    check_eq("arst_push_ready", 32'(fq.push_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
